// File: rtl/usc_pkg.sv
// Shared definitions for the goML stage acknowledge responder.
//   resp_state_t : responder FSM state encoding
//   RCNT_W       : width of the recovery-window down-counter (holds 0..15)
package usc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EVAL    = 3'd1,
    ST_RECOVER = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } resp_state_t;

  localparam int RCNT_W = $clog2(16);

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchroniser chain of DEPTH flops, cleared by a synchronous reset.
// With DEPTH = 0 the input is passed straight through (same-domain use).
//   clk : clock
//   rst : synchronous, active-high reset
//   i_d : asynchronous (or same-domain) input bit
//   o_q : synchronised output bit
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_chain
      logic [DEPTH-1:0] r_chain;

      // Shift the input through the flop chain; the oldest bit is the output.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_chain <= '0;
        end else begin
          r_chain <= (r_chain << 1) | DEPTH'(i_d);
        end
      end

      assign o_q = r_chain[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/reack_responder.sv
// Receiving-side responder for the resilient (goML) pipeline stage.
// Synchronises Rreq/Err0/Err1, acknowledges clean transfers after a fixed
// latency and holds flagged transfers for RECOVER_CYCLES before acknowledging.
// Also keeps error statistics and a sticky protocol-violation flag.
//   clk       : clock
//   rst       : synchronous, active-high reset
//   Rreq      : four-phase request from the stage controller
//   Err0/Err1 : timing-error flags, stable while Rreq is high
//   REack     : four-phase acknowledge (registered)
//   sample    : one-cycle pulse while the flags are captured (registered)
//   err_seen  : last completed transfer was flagged (registered)
//   err_cnt   : saturating count of flagged transfers (registered)
//   violation : sticky protocol-violation flag (registered)
module reack_responder
  import usc_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int RECOVER_CYCLES = 3,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Rreq,
  input  logic             Err0,
  input  logic             Err1,
  output logic             REack,
  output logic             sample,
  output logic             err_seen,
  output logic [CNT_W-1:0] err_cnt,
  output logic             violation
);

  logic w_rq;
  logic w_e0;
  logic w_e1;

  resp_state_t       r_state;
  logic [RCNT_W-1:0] r_rcnt;
  logic              r_err;
  logic              r_reack;
  logic              r_sample;
  logic              r_err_seen;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_violation;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_rq (.clk(clk), .rst(rst), .i_d(Rreq), .o_q(w_rq));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_e0 (.clk(clk), .rst(rst), .i_d(Err0), .o_q(w_e0));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_e1 (.clk(clk), .rst(rst), .i_d(Err1), .o_q(w_e1));

  // Handshake FSM with recovery counter, statistics and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rcnt      <= {RCNT_W{1'b0}};
      r_err       <= 1'b0;
      r_reack     <= 1'b0;
      r_sample    <= 1'b0;
      r_err_seen  <= 1'b0;
      r_err_cnt   <= {CNT_W{1'b0}};
      r_violation <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_reack <= 1'b0;
          if (w_rq) begin
            // sample is raised together with the EVAL state, so it is high
            // exactly for the capture cycle.
            r_state  <= ST_EVAL;
            r_sample <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          r_err <= w_e0 | w_e1;
          // Both flags at once, or the request already withdrawn, is illegal.
          if ((w_e0 & w_e1) | ~w_rq) begin
            r_violation <= 1'b1;
          end
          if (w_e0 | w_e1) begin
            r_rcnt  <= RCNT_W'(RECOVER_CYCLES - 1);
            r_state <= ST_RECOVER;
          end else begin
            r_state <= ST_ACK;
          end
        end
        ST_RECOVER: begin
          if (!w_rq) begin
            r_violation <= 1'b1;
          end
          if (r_rcnt == {RCNT_W{1'b0}}) begin
            r_state <= ST_ACK;
          end else begin
            r_rcnt  <= r_rcnt - RCNT_W'(1);
            r_state <= ST_RECOVER;
          end
        end
        ST_ACK: begin
          // ACK lasts a single cycle, so statistics update exactly once.
          r_reack    <= 1'b1;
          r_err_seen <= r_err;
          if (r_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!w_rq) begin
            r_reack <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_reack <= 1'b1;
            r_state <= ST_RELEASE;
          end
        end
        default: begin
          r_reack <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign REack     = r_reack;
  assign sample    = r_sample;
  assign err_seen  = r_err_seen;
  assign err_cnt   = r_err_cnt;
  assign violation = r_violation;

endmodule

// File: tb/tb_reack_responder.sv
// Directed self-checking bench for reack_responder
// (SYNC_STAGES=2, RECOVER_CYCLES=3, CNT_W=2).
module tb_reack_responder;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             Rreq;
  logic             Err0;
  logic             Err1;
  logic             REack;
  logic             sample;
  logic             err_seen;
  logic [CNT_W-1:0] err_cnt;
  logic             violation;

  int checks = 0;
  int errors = 0;

  reack_responder #(
    .SYNC_STAGES(2),
    .RECOVER_CYCLES(3),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Rreq(Rreq),
    .Err0(Err0),
    .Err1(Err1),
    .REack(REack),
    .sample(sample),
    .err_seen(err_seen),
    .err_cnt(err_cnt),
    .violation(violation)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; Rreq = 1'b0; Err0 = 1'b0; Err1 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full four-phase transfer; latencies are counted in edges from the pin change.
  task automatic handshake(input logic e0, input logic e1,
                           output int ack_lat, output int rel_lat, output int samples);
    Err0 = e0; Err1 = e1; Rreq = 1'b1;
    samples = 0; ack_lat = -1; rel_lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (sample) samples++;
      if (REack) begin ack_lat = c; break; end
    end
    Rreq = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (sample) samples++;
      if (!REack) begin rel_lat = c; break; end
    end
    Err0 = 1'b0; Err1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int a, r, s;
    rst = 1'b1; Rreq = 1'b1; Err0 = 1'b0; Err1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({REack, sample, err_seen, err_cnt, violation} !== {3'b000, {CNT_W{1'b0}}, 1'b0}) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b expected all zero", c,
                 {REack, sample, err_seen, err_cnt, violation});
      end
    end
    rst = 1'b0; Rreq = 1'b0;
    @(posedge clk); #1;
    handshake(1'b0, 1'b0, a, r, s);
    checks++;
    if (a !== 5) begin errors++; $display("FAIL reset_then_ack_latency: got %0d expected 5", a); end
  endtask

  task automatic test_clean();
    int a, r, s;
    do_reset();
    handshake(1'b0, 1'b0, a, r, s);
    checks++;
    if (a !== 5) begin errors++; $display("FAIL clean_ack_latency: got %0d expected 5", a); end
    checks++;
    if (r !== 3) begin errors++; $display("FAIL clean_release_latency: got %0d expected 3", r); end
    checks++;
    if (s !== 1) begin errors++; $display("FAIL clean_sample_pulses: got %0d expected 1", s); end
    checks++;
    if (err_cnt !== 2'd0) begin errors++; $display("FAIL clean_err_cnt: got %0d expected 0", err_cnt); end
    checks++;
    if (err_seen !== 1'b0) begin errors++; $display("FAIL clean_err_seen: got %b expected 0", err_seen); end
    checks++;
    if (violation !== 1'b0) begin errors++; $display("FAIL clean_violation: got %b expected 0", violation); end
  endtask

  task automatic test_error();
    int a, r, s;
    do_reset();
    handshake(1'b0, 1'b1, a, r, s);
    checks++;
    if (a !== 8) begin errors++; $display("FAIL error_ack_latency: got %0d expected 8", a); end
    checks++;
    if (r !== 3) begin errors++; $display("FAIL error_release_latency: got %0d expected 3", r); end
    checks++;
    if (s !== 1) begin errors++; $display("FAIL error_sample_pulses: got %0d expected 1", s); end
    checks++;
    if (err_cnt !== 2'd1) begin errors++; $display("FAIL error_err_cnt: got %0d expected 1", err_cnt); end
    checks++;
    if (err_seen !== 1'b1) begin errors++; $display("FAIL error_err_seen: got %b expected 1", err_seen); end
    checks++;
    if (violation !== 1'b0) begin errors++; $display("FAIL error_violation: got %b expected 0", violation); end
    handshake(1'b0, 1'b0, a, r, s);
    checks++;
    if (a !== 5) begin errors++; $display("FAIL follow_clean_latency: got %0d expected 5", a); end
    checks++;
    if (err_seen !== 1'b0) begin errors++; $display("FAIL follow_clean_err_seen: got %b expected 0", err_seen); end
    checks++;
    if (err_cnt !== 2'd1) begin errors++; $display("FAIL follow_clean_err_cnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_saturation();
    int a, r, s;
    logic [CNT_W-1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      handshake(i[0], ~i[0], a, r, s);
      checks++;
      if (err_cnt !== exp_cnt[i]) begin
        errors++;
        $display("FAIL saturation_cnt[%0d]: got %0d expected %0d", i, err_cnt, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_violation_both();
    int a, r, s;
    do_reset();
    handshake(1'b1, 1'b1, a, r, s);
    checks++;
    if (violation !== 1'b1) begin errors++; $display("FAIL both_flags_violation: got %b expected 1", violation); end
    checks++;
    if (a !== 8) begin errors++; $display("FAIL both_flags_latency: got %0d expected 8", a); end
    for (int i = 0; i < 2; i++) begin
      handshake(1'b0, 1'b0, a, r, s);
      checks++;
      if (violation !== 1'b1) begin errors++; $display("FAIL violation_sticky[%0d]: got %b expected 1", i, violation); end
    end
  endtask

  task automatic test_violation_drop();
    int highs;
    do_reset();
    checks++;
    if (violation !== 1'b0) begin errors++; $display("FAIL drop_pre_violation: got %b expected 0", violation); end
    Err0 = 1'b1; Rreq = 1'b1;
    // Four edges in, the FSM has just entered RECOVER.
    repeat (4) begin @(posedge clk); #1; end
    Rreq = 1'b0;
    highs = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (REack) highs++;
    end
    Err0 = 1'b0;
    checks++;
    if (highs !== 1) begin errors++; $display("FAIL drop_reack_cycles: got %0d expected 1", highs); end
    checks++;
    if (violation !== 1'b1) begin errors++; $display("FAIL drop_violation: got %b expected 1", violation); end
    checks++;
    if (err_cnt !== 2'd1) begin errors++; $display("FAIL drop_err_cnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    Err1 = 1'b1; Rreq = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if ({REack, err_cnt} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL midrst_pre: got REack=%b err_cnt=%0d expected REack=1 err_cnt=1", REack, err_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (REack !== 1'b0) begin errors++; $display("FAIL midrst_reack: got %b expected 0", REack); end
    checks++;
    if (err_cnt !== 2'd0) begin errors++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt); end
    rst = 1'b0; Rreq = 1'b0; Err1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (REack !== 1'b0) begin errors++; $display("FAIL midrst_after: got %b expected 0", REack); end
  endtask

  initial begin
    rst = 1'b1; Rreq = 1'b0; Err0 = 1'b0; Err1 = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_clean();
    test_error();
    test_saturation();
    test_violation_both();
    test_violation_drop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reack_responder.md
# reack_responder

Synchronous responder for the goML stage handshake. It receives `Rreq` together with the `Err0`/`Err1` timing-error flags from an error-detecting stage controller, and returns `REack` once the stage may advance. Error-free transfers get a short, fixed latency. Flagged transfers are held for a programmable recovery window before they are acknowledged. The block sits on the receiving side of the resilient pipeline stage, in the clocked domain, and also exports error statistics.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on `Rreq`, `Err0`, `Err1`. Legal values are 0 (same-domain inputs) or 2–3.
- `RECOVER_CYCLES`, 3: cycles spent in RECOVER after an error, before acknowledging. Legal range 1–15.
- `CNT_W`, 8: width of the saturating error counter.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `Rreq`, input, 1: request from the stage controller, four-phase.
- `Err0`, input, 1: error flag 0; must be stable while `Rreq` is high.
- `Err1`, input, 1: error flag 1; same stability rule as `Err0`.
- `REack`, output, 1: acknowledge, four-phase.
- `sample`, output, 1: one-cycle pulse when the flags are captured.
- `err_seen`, output, 1: the last completed transfer was flagged; registered.
- `err_cnt`, output, CNT_W: saturating count of flagged transfers.
- `violation`, output, 1: sticky flag for a protocol violation.

## Operation
- Inputs pass through `SYNC_STAGES` flops. All descriptions below refer to the synchronised versions: `rq`, `e0`, `e1`.
- FSM states: IDLE, EVAL, RECOVER, ACK, RELEASE.
- **IDLE**
  - `REack` = 0.
  - If `rq` = 1, go to EVAL.
- **EVAL** (one cycle)
  - `sample` = 1.
  - Capture `err = e0 | e1`.
  - If `e0 & e1`, set `violation`.
  - If `err`, load the recovery counter with `RECOVER_CYCLES-1` and go to RECOVER; otherwise go to ACK.
- **RECOVER**
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to ACK.
- **ACK**
  - `REack` = 1.
  - `err_seen` is updated from the captured `err`.
  - If `err`, `err_cnt` is incremented, saturating at all-ones.
  - The update happens exactly once, on entry.
  - Go to RELEASE.
- **RELEASE**
  - `REack` stays 1 until `rq` = 0.
  - Then `REack` falls and the FSM returns to IDLE.
- Protocol violations:
  - `rq` falling in EVAL or RECOVER sets `violation`.
  - The FSM still completes the ack phase: it passes through ACK for one cycle, then returns to IDLE through RELEASE.
  - `err_cnt` is still updated.
- A new `rq` rise while in RELEASE is impossible under the four-phase rule. It is not detected separately.
- `violation` and `err_cnt` clear only on `rst`.

## Timing
- Reset values: `REack`=0, `sample`=0, `err_seen`=0, `err_cnt`=0, `violation`=0, FSM=IDLE, synchroniser flops=0.
- Reset takes priority over every other event on the same edge. Asserting `rst` mid-handshake drops `REack` on the next edge.
- `sample` is high for exactly one cycle per transfer.
- All outputs are registered; there is no combinational input-to-output path.
- Latency is counted from the `Rreq` rise at the pin to `REack` = 1:
  - No error: `SYNC_STAGES` + 3 cycles (IDLE→EVAL, EVAL→ACK, registered output).
  - Error: `SYNC_STAGES` + 3 + `RECOVER_CYCLES` cycles.
- Release latency, from the `Rreq` fall to `REack` = 0: `SYNC_STAGES` + 1 cycles.
- With `SYNC_STAGES` = 0, back-to-back transfers may restart in IDLE on the cycle after RELEASE exits.
- Counter saturation: at `err_cnt` = 2^CNT_W − 1, a further error holds the value.

## Structure
- Shared package `usc_pkg` holds:
  - the FSM state enum `resp_state_t` (IDLE, EVAL, RECOVER, ACK, RELEASE);
  - the localparam for recovery-counter width, `$clog2(16)`.
- Sub-module `sync_ff`: a parameterised-depth flop chain for a single bit, instantiated three times. With depth 0 it is a pass-through.
- The FSM, the recovery counter and the statistics stay in `reack_responder`.

## Test plan
1. **Reset.** `rst`=1 for 3 cycles while `Rreq`=1 → all outputs 0 throughout. After release, a handshake starts normally.
2. **Clean transfer.** `SYNC_STAGES`=2; `Rreq`↑ with `Err0`=`Err1`=0 → `sample` pulses once, `REack`↑ 5 cycles later. `Rreq`↓ → `REack`↓ after 3 cycles. `err_cnt`=0, `err_seen`=0.
3. **Error transfer.** `Err1`=1, `RECOVER_CYCLES`=3 → `REack`↑ 8 cycles after `Rreq`↑. `err_cnt`=1, `err_seen`=1. A following clean transfer gives `err_seen`=0 and `err_cnt` still 1.
4. **Saturation.** `CNT_W`=2; five flagged transfers → `err_cnt` sequence 1, 2, 3, 3, 3.
5. **Violations.**
   - `Err0`=`Err1`=1 → `violation`=1, which persists through later clean transfers.
   - `Rreq` dropped during RECOVER → `violation`=1, `REack` pulses for exactly one cycle.
6. **Mid-handshake reset.** `rst` asserted while in RELEASE with `REack`=1 → `REack`=0 on the next edge, `err_cnt`=0.
